// File: rtl/nco_bank.sv
// nco_bank: a bank of independent phase-accumulator oscillators.
// Each channel has its own frequency word, phase offset and waveform mode.
// A new frequency word waits in a shadow register and is committed at the
// channel's next wrap, or at once when the channel is not advancing. This
// avoids a glitch in the running waveform when the frequency changes.
module nco_bank #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      sync,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [ACC_W-1:0]          cfg_data,
    output logic [CHANNELS*OUT_W-1:0] wave_out,
    output logic [CHANNELS-1:0]       wrap_out
);

    logic [ACC_W-1:0]          acc_q        [CHANNELS];
    logic [ACC_W-1:0]          acc_d        [CHANNELS];
    logic [ACC_W-1:0]          fwordAct_q   [CHANNELS];
    logic [ACC_W-1:0]          fwordShadow_q[CHANNELS];
    logic [ACC_W-1:0]          offset_q     [CHANNELS];
    logic [1:0]                mode_q       [CHANNELS];
    logic [CHANNELS-1:0]       pending_q;
    logic [CHANNELS*OUT_W-1:0] wave_q;
    logic [CHANNELS*OUT_W-1:0] wave_d;
    logic [CHANNELS-1:0]       wrap_q;
    logic [CHANNELS-1:0]       wrap_d;

    logic [ACC_W:0]            accSum       [CHANNELS];
    logic [ACC_W-1:0]          phase        [CHANNELS];
    logic [OUT_W-1:0]          triBits      [CHANNELS];
    logic [CHANNELS-1:0]       commit;
    logic [CHANNELS-1:0]       wrEn;
    logic                      accept;

    // A channel refuses writes while it still holds an uncommitted frequency word.
    // Channel numbers past the end of the bank are always ready and their writes are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending_q[i];
            end
        end
    end

    // Decode which channel the accepted write targets.
    always_comb begin
        accept = cfg_valid && cfg_ready;
        wrEn   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrEn[i] = accept && (cfg_ch == CH_W'(i));
        end
    end

    // Compute the per-channel accumulator step, wrap and commit, and the next sample.
    always_comb begin
        wave_d = '0;
        wrap_d = '0;
        commit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accSum[i]  = {1'b0, acc_q[i]} + {1'b0, fwordAct_q[i]};
            wrap_d[i]  = !sync && ena && accSum[i][ACC_W];
            acc_d[i]   = sync ? '0 : (ena ? accSum[i][ACC_W-1:0] : acc_q[i]);
            commit[i]  = pending_q[i] &&
                         (wrap_d[i] || sync || !ena || (fwordAct_q[i] == '0));
            phase[i]   = acc_q[i] + offset_q[i];
            triBits[i] = phase[i][ACC_W-2 -: OUT_W];
            case (mode_q[i])
                2'd0:    wave_d[i*OUT_W +: OUT_W] = phase[i][ACC_W-1 -: OUT_W];
                2'd1:    wave_d[i*OUT_W +: OUT_W] = {OUT_W{phase[i][ACC_W-1]}};
                2'd2:    wave_d[i*OUT_W +: OUT_W] = phase[i][ACC_W-1] ? ~triBits[i] : triBits[i];
                default: wave_d[i*OUT_W +: OUT_W] = '0;
            endcase
        end
    end

    // Advance the accumulators and register the samples and wrap pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            wave_q <= '0;
            wrap_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
            end
            wave_q <= wave_d;
            wrap_q <= wrap_d;
        end
    end

    // Accept configuration writes and commit shadowed frequency words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                fwordAct_q[i]    <= '0;
                fwordShadow_q[i] <= '0;
                offset_q[i]      <= '0;
                mode_q[i]        <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (commit[i]) begin
                    fwordAct_q[i] <= fwordShadow_q[i];
                    pending_q[i]  <= 1'b0;
                end
                if (wrEn[i]) begin
                    case (cfg_sel)
                        2'd0: begin
                            fwordShadow_q[i] <= cfg_data;
                            pending_q[i]     <= 1'b1;
                        end
                        2'd1:    offset_q[i] <= cfg_data;
                        2'd2:    mode_q[i]   <= cfg_data[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign wave_out = wave_q;
    assign wrap_out = wrap_q;

endmodule

// File: tb/tb_nco_bank.sv
// tb_nco_bank: directed scenarios and randomized traffic for nco_bank,
// checked every cycle against an arithmetic model of the oscillator bank.
module tb_nco_bank;

    localparam int CH = 4;
    localparam int AW = 24;
    localparam int OW = 8;
    localparam int CW = 2;
    localparam longint unsigned MOD = 64'd1 << AW;

    logic           clk;
    logic           rst;
    logic           ena;
    logic           sync;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [1:0]     cfg_sel;
    logic [AW-1:0]  cfg_data;
    logic [CH*OW-1:0] wave_out;
    logic [CH-1:0]  wrap_out;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 0;

    // Model state: one entry per channel
    longint unsigned mAcc [CH];
    longint unsigned mAct [CH];
    longint unsigned mSh  [CH];
    longint unsigned mOff [CH];
    int              mMode[CH];
    bit              mPend[CH];
    logic [CH*OW-1:0] expWave;
    logic [CH-1:0]    expWrap;

    nco_bank #(.CHANNELS(CH), .ACC_W(AW), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .wave_out  (wave_out),
        .wrap_out  (wrap_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value for a phase, from the waveform definitions
    function automatic longint unsigned waveOf(input longint unsigned a, input longint unsigned o, input int m);
        longint unsigned p;
        longint unsigned u;
        longint unsigned top;
        p   = (a + o) % MOD;
        top = (64'd1 << OW) - 1;
        u   = (p >> (AW - 1 - OW)) & top;
        case (m)
            0:       return p >> (AW - OW);
            1:       return (p >= MOD / 2) ? top : 64'd0;
            2:       return (p >= MOD / 2) ? (top - u) : u;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit modelReady(input int ch);
        if (ch >= CH) return 1'b1;
        return !mPend[ch];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            mAcc[i] = 0; mAct[i] = 0; mSh[i] = 0; mOff[i] = 0; mMode[i] = 0; mPend[i] = 0;
        end
        expWave = '0;
        expWrap = '0;
    endtask

    task automatic modelStep();
        logic [CH*OW-1:0] newWave;
        logic [CH-1:0]    newWrap;
        bit               acc;
        bit               doCommit;
        newWave = '0;
        newWrap = '0;
        acc = cfg_valid && modelReady(int'(cfg_ch));
        for (int i = 0; i < CH; i++) begin
            newWave[i*OW +: OW] = OW'(waveOf(mAcc[i], mOff[i], mMode[i]));
            newWrap[i] = !sync && ena && (mAcc[i] + mAct[i] >= MOD);
            doCommit = mPend[i] && (newWrap[i] || sync || !ena || mAct[i] == 0);
            if (sync)     mAcc[i] = 0;
            else if (ena) mAcc[i] = (mAcc[i] + mAct[i]) % MOD;
            if (doCommit) begin
                mAct[i]  = mSh[i];
                mPend[i] = 0;
            end
            if (acc && int'(cfg_ch) == i) begin
                case (cfg_sel)
                    2'd0: begin mSh[i] = cfg_data; mPend[i] = 1; end
                    2'd1: mOff[i]  = cfg_data;
                    2'd2: mMode[i] = int'(cfg_data[1:0]);
                    default: ;
                endcase
            end
        end
        expWave = newWave;
        expWrap = newWrap;
    endtask

    // Model advances on every clock edge and clears on reset
    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) modelReset();
            else     modelStep();
        end
    end

    // Compare DUT against the model once per cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn && !rst) begin
                checkOutput("wave_out", wave_out, expWave);
                checkOutput("wrap_out", wrap_out, expWrap);
                checkOutput("cfg_ready", cfg_ready, modelReady(int'(cfg_ch)));
            end
        end
    end

    // Issue one config write, holding valid until it is accepted
    task automatic writeCfg(input int ch, input int sel, input logic [AW-1:0] data, output int stalls);
        bit rdy;
        bit done;
        stalls = 0;
        done   = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_sel   = 2'(sel);
        cfg_data  = data;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            rdy = cfg_ready;
            @(posedge clk); #1;
            if (rdy) done = 1;
            else     stalls++;
        end
        cfg_valid = 1'b0;
        if (!done) checkOutput("write_accept_timeout", 0, 1);
    endtask

    task automatic waitWave(input int ch, input logic [OW-1:0] val);
        bit found;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (wave_out[ch*OW +: OW] == val) found = 1;
        end
        checkOutput("wait_wave", found, 1);
    endtask

    task automatic waitReady();
        bit found;
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (cfg_ready) found = 1;
        end
        checkOutput("wait_ready", found, 1);
    endtask

    // One cycle of randomized traffic
    task automatic applyStimulus();
        int kind;
        @(posedge clk); #1;
        ena       = ($urandom_range(0, 9) != 0);
        sync      = ($urandom_range(0, 59) == 0);
        cfg_valid = ($urandom_range(0, 2) == 0);
        cfg_ch    = CW'($urandom_range(0, CH - 1));
        cfg_sel   = 2'($urandom_range(0, 3));
        kind      = $urandom_range(0, 3);
        case (kind)
            0:       cfg_data = '0;
            1:       cfg_data = AW'($urandom_range(1, 16) << 16);
            2:       cfg_data = AW'($urandom_range(0, 255) << 12);
            default: cfg_data = AW'($urandom);
        endcase
    endtask

    initial begin
        int st;
        int st2;
        rst = 1'b0; ena = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wave", wave_out, 0);
        checkOutput("reset_wrap", wrap_out, 0);
        checkOutput("reset_ready", cfg_ready, 1);
        @(negedge clk); #1;
        rst = 1'b0;
        checkEn = 1;

        // Saw on ch0: immediate commit, 16-step ramp, wrap each period
        @(posedge clk); #1;
        ena = 1'b1;
        writeCfg(0, 0, 24'h100000, st);
        checkOutput("first_write_stall", st, 0);
        waitWave(0, 8'h10);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checkOutput("saw_step", wave_out[7:0], (8'h10 * (k + 1)) & 8'hFF);
            checkOutput("saw_wrap", wrap_out[0], (k == 14));
        end

        // Glitch-free update mid-period; a second write stalls until commit
        writeCfg(0, 0, 24'h200000, st);
        checkOutput("glitch_first_stall", st, 0);
        @(negedge clk);
        checkOutput("glitch_ready_low", cfg_ready, 0);
        writeCfg(0, 0, 24'h300000, st2);
        checkOutput("glitch_second_stalled", (st2 > 0), 1);

        // Modes on ch1
        writeCfg(1, 2, 24'd1, st);
        writeCfg(1, 0, 24'h080000, st);
        repeat (70) @(posedge clk);
        writeCfg(1, 2, 24'd2, st);
        repeat (70) @(posedge clk);
        writeCfg(1, 2, 24'd3, st);
        repeat (2) @(negedge clk);
        checkOutput("mute_zero", wave_out[15:8], 8'h00);
        repeat (10) @(posedge clk);

        // Phase offset: ch3 square is the inverse of ch2
        writeCfg(2, 2, 24'd1, st);
        writeCfg(3, 2, 24'd1, st);
        writeCfg(3, 1, 24'h800000, st);
        writeCfg(2, 0, 24'h040000, st);
        writeCfg(3, 0, 24'h040000, st);
        @(posedge clk); #1 sync = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("offset_ch2", wave_out[23:16], 8'h00);
        checkOutput("offset_ch3", wave_out[31:24], 8'hFF);
        repeat (80) @(posedge clk);

        // Sync coinciding with a wrap on ch0 that also has a pending word
        writeCfg(0, 0, 24'h100000, st);
        waitReady();
        repeat (2) @(negedge clk);
        waitWave(0, 8'hC0);
        #1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 24'h200000;
        @(negedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_sync_wave", wave_out[7:0], 8'hE0);
        #1 sync = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
        @(negedge clk);
        checkOutput("sync_no_wrap", wrap_out, 4'h0);
        checkOutput("sync_commit_ready", cfg_ready, 1);
        @(negedge clk);
        checkOutput("sync_saw_zero", wave_out[7:0], 8'h00);
        repeat (20) @(posedge clk);

        // ena low: outputs frozen, writes commit immediately
        @(posedge clk); #1 ena = 1'b0;
        writeCfg(2, 0, 24'h123456, st);
        checkOutput("ena0_stall", st, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("ena0_no_wrap", wrap_out, 4'h0);
        end
        @(posedge clk); #1 ena = 1'b1;
        repeat (20) @(posedge clk);

        // Asynchronous reset mid-run discards a pending word
        writeCfg(1, 0, 24'h100000, st);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_wave", wave_out, 0);
        checkOutput("async_rst_wrap", wrap_out, 0);
        checkOutput("async_rst_ready", cfg_ready, 1);
        @(negedge clk); #1 rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0; sync = 1'b0;
        repeat (4) @(posedge clk);
        checkEn = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
